// File: rtl/instruction_fetch_pkg.sv
// Shared RISC-V fetch definitions: reset vector, instruction width, NOP encoding
// and the default geometry of the fetch stage.
package instruction_fetch_pkg;

  localparam int unsigned RV_INSTR_W    = 32;
  localparam logic [31:0] RV_NOP        = 32'h0000_0013;
  localparam int unsigned RV_RESET_PC   = 0;
  localparam int unsigned IF_ADDR_W     = 10;
  localparam int unsigned IF_FIFO_DEPTH = 4;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect input and the
// decode-side valid/ready output.
interface instruction_fetch_if #(
  parameter int unsigned ADDRESS_WIDTH = 10,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic                     im_ce;
  logic [ADDRESS_WIDTH-1:0] im_address;
  logic [DATA_WIDTH-1:0]    im_data;
  logic                     im_data_valid;
  logic                     redirect_valid;
  logic [ADDRESS_WIDTH-1:0] redirect_pc;
  logic                     out_valid;
  logic [DATA_WIDTH-1:0]    out_instr;
  logic [ADDRESS_WIDTH-1:0] out_pc;
  logic                     out_ready;

  modport master (
    output im_ce, im_address, out_valid, out_instr, out_pc,
    input  im_data, im_data_valid, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  im_ce, im_address, out_valid, out_instr, out_pc,
    output im_data, im_data_valid, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instruction_fetch_fifo.sv
// Synchronous instruction buffer with flush; the head reads as zero when empty
// so the fetch outputs are clean without resetting the storage array.
module instruction_fetch_fifo #(
  parameter  int unsigned WIDTH = 42,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, single outstanding memory read and credit-based issue into a
// small instruction buffer, with a redirect that flushes all younger work.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = IF_ADDR_W,
  parameter int unsigned DATA_WIDTH    = RV_INSTR_W,
  parameter int unsigned RESET_PC      = RV_RESET_PC,
  parameter int unsigned FIFO_DEPTH    = IF_FIFO_DEPTH
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_if.master bus
);

  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENTRY_W = DATA_WIDTH + ADDRESS_WIDTH;

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                     inflight_q, inflight_d;
  logic [CNT_W-1:0]         fifo_count;
  logic [CNT_W:0]           credit_used;
  logic                     credit_ok, issue, push, pop, redirect;
  logic [ENTRY_W-1:0]       head;

  assign redirect = bus.redirect_valid;

  // Buffered entries plus the outstanding read may never exceed the buffer,
  // so a response always has a slot; the rst term keeps im_ce low in reset.
  assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign credit_ok   = credit_used < (CNT_W + 1)'(FIFO_DEPTH);
  assign issue       = rst && !redirect && credit_ok;
  assign push        = bus.im_data_valid && inflight_q && !redirect;
  assign pop         = bus.out_valid && bus.out_ready;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    if (redirect) begin
      pc_d       = bus.redirect_pc;
      inflight_d = 1'b0;
    end else if (issue) begin
      pc_d          = pc_q + ADDRESS_WIDTH'(1);
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end else if (push) begin
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= ADDRESS_WIDTH'(RESET_PC);
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
  end

  instruction_fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .data_i  ({bus.im_data, inflight_pc_q}),
    .data_o  (head),
    .count_o (fifo_count)
  );

  assign bus.im_ce      = issue;
  assign bus.im_address = pc_q;
  assign bus.out_valid  = (fifo_count != '0) && !redirect;
  assign bus.out_instr  = head[ENTRY_W-1:ADDRESS_WIDTH];
  assign bus.out_pc     = head[ADDRESS_WIDTH-1:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized run
// against a queue-based model of issued fetches and their arrival times.
module tb_instruction_fetch;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic spur_en = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  instruction_fetch_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  instruction_fetch #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .RESET_PC      (0),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return 32'(a) + 32'd100;
  endfunction

  // Instruction memory: word k holds k+100, answers the cycle after im_ce;
  // optionally injects spurious strobes with garbage data when idle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.im_data_valid <= 1'b0;
      bus.im_data       <= '0;
    end else if (bus.im_ce) begin
      bus.im_data_valid <= 1'b1;
      bus.im_data       <= word(bus.im_address);
    end else if (spur_en && ($urandom % 4 == 0)) begin
      bus.im_data_valid <= 1'b1;
      bus.im_data       <= $urandom;
    end else begin
      bus.im_data_valid <= 1'b0;
    end
  end

  task automatic step(input logic rv, input logic [AW-1:0] rpc, input logic rdy);
    @(negedge clk);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic release_reset(input logic rdy);
    @(negedge clk);
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.out_ready      = rdy;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (bus.im_ce !== 1'b0) begin n_err++; $display("FAIL reset_im_ce: got %b want 0", bus.im_ce); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.out_instr !== '0) begin n_err++; $display("FAIL reset_out_instr: got %h want 0", bus.out_instr); end
    n_vec++; if (bus.out_pc !== '0) begin n_err++; $display("FAIL reset_out_pc: got %h want 0", bus.out_pc); end
  endtask

  task automatic test_stream();
    do_reset();
    release_reset(1'b1);
    n_vec++; if (bus.im_ce !== 1'b1) begin n_err++; $display("FAIL stream_c1_ce: got %b want 1", bus.im_ce); end
    n_vec++; if (bus.im_address !== 10'd0) begin n_err++; $display("FAIL stream_c1_addr: got %h want 0", bus.im_address); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stream_c1_valid: got %b want 0", bus.out_valid); end
    step(1'b0, '0, 1'b1);
    n_vec++; if (bus.im_address !== 10'd1) begin n_err++; $display("FAIL stream_c2_addr: got %h want 1", bus.im_address); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stream_c2_valid: got %b want 0", bus.out_valid); end
    for (int k = 0; k < 8; k++) begin
      step(1'b0, '0, 1'b1);
      n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want 1", k, bus.out_valid); end
      n_vec++; if (bus.out_pc !== AW'(k)) begin n_err++; $display("FAIL stream_pc[%0d]: got %h want %h", k, bus.out_pc, AW'(k)); end
      n_vec++; if (bus.out_instr !== word(AW'(k))) begin n_err++; $display("FAIL stream_instr[%0d]: got %h want %h", k, bus.out_instr, word(AW'(k))); end
      n_vec++; if (bus.im_ce !== 1'b1) begin n_err++; $display("FAIL stream_ce[%0d]: got %b want 1", k, bus.im_ce); end
    end
  endtask

  task automatic test_backpressure();
    int issues;
    logic [AW-1:0] exp_pc;
    do_reset();
    release_reset(1'b0);
    issues = int'(bus.im_ce);
    for (int c = 2; c <= 10; c++) begin
      step(1'b0, '0, 1'b0);
      issues += int'(bus.im_ce);
    end
    n_vec++; if (issues != DEPTH) begin n_err++; $display("FAIL bp_issue_count: got %0d want %0d", issues, DEPTH); end
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 10'd0) begin n_err++; $display("FAIL bp_head: got valid %b pc %h want 1/0", bus.out_valid, bus.out_pc); end
    exp_pc = '0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, '0, 1'b1);
      n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc) begin n_err++; $display("FAIL bp_drain[%0d]: got valid %b pc %h want 1/%h", k, bus.out_valid, bus.out_pc, exp_pc); end
      n_vec++; if (bus.out_instr !== word(exp_pc)) begin n_err++; $display("FAIL bp_instr[%0d]: got %h want %h", k, bus.out_instr, word(exp_pc)); end
      if (k < 2) begin
        n_vec++; if (bus.im_ce !== logic'(k == 1)) begin n_err++; $display("FAIL bp_resume[%0d]: got ce %b want %b", k, bus.im_ce, logic'(k == 1)); end
      end
      exp_pc = exp_pc + 1'b1;
    end
  endtask

  task automatic test_redirect();
    do_reset();
    release_reset(1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, 10'h200, 1'b1);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL redir_R_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.im_ce !== 1'b0) begin n_err++; $display("FAIL redir_R_ce: got %b want 0", bus.im_ce); end
    step(1'b0, '0, 1'b1);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL redir_R1_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.im_ce !== 1'b1 || bus.im_address !== 10'h200) begin n_err++; $display("FAIL redir_R1_issue: got ce %b addr %h want 1/200", bus.im_ce, bus.im_address); end
    step(1'b0, '0, 1'b1);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL redir_R2_valid: got %b want 0", bus.out_valid); end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0, 1'b1);
      n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 10'h200 + AW'(k)) begin n_err++; $display("FAIL redir_out[%0d]: got valid %b pc %h want 1/%h", k, bus.out_valid, bus.out_pc, 10'h200 + AW'(k)); end
      n_vec++; if (bus.out_instr !== word(10'h200 + AW'(k))) begin n_err++; $display("FAIL redir_instr[%0d]: got %h want %h", k, bus.out_instr, word(10'h200 + AW'(k))); end
    end
  endtask

  task automatic test_back_to_back();
    int  waited;
    step(1'b1, 10'h010, 1'b1);
    step(1'b1, 10'h040, 1'b1);
    n_vec++; if (bus.im_ce !== 1'b0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_R1: got ce %b valid %b want 0/0", bus.im_ce, bus.out_valid); end
    waited = 0;
    do begin
      step(1'b0, '0, 1'b1);
      waited++;
    end while (bus.out_valid !== 1'b1 && waited < 10);
    n_vec++; if (waited != 3) begin n_err++; $display("FAIL b2b_latency: got %0d cycles want 3", waited); end
    n_vec++; if (bus.out_pc !== 10'h040) begin n_err++; $display("FAIL b2b_first_pc: got %h want 040", bus.out_pc); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] wexp [4];
    int got;
    wexp[0] = 10'h3FE; wexp[1] = 10'h3FF; wexp[2] = 10'h000; wexp[3] = 10'h001;
    step(1'b1, 10'h3FE, 1'b1);
    got = 0;
    for (int c = 0; c < 12 && got < 4; c++) begin
      step(1'b0, '0, 1'b1);
      if (bus.out_valid === 1'b1) begin
        n_vec++; if (bus.out_pc !== wexp[got]) begin n_err++; $display("FAIL wrap_pc[%0d]: got %h want %h", got, bus.out_pc, wexp[got]); end
        n_vec++; if (bus.out_instr !== word(wexp[got])) begin n_err++; $display("FAIL wrap_instr[%0d]: got %h want %h", got, bus.out_instr, word(wexp[got])); end
        got++;
      end
    end
    n_vec++; if (got != 4) begin n_err++; $display("FAIL wrap_count: got %0d want 4", got); end
  endtask

  task automatic test_reset_midstream();
    repeat (8) step(1'b0, '0, 1'b0);
    n_vec++; if (bus.out_valid !== 1'b1 || bus.im_ce !== 1'b0) begin n_err++; $display("FAIL mid_full: got valid %b ce %b want 1/0", bus.out_valid, bus.im_ce); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (bus.out_valid !== 1'b0 || bus.im_ce !== 1'b0) begin n_err++; $display("FAIL mid_rst_drop: got valid %b ce %b want 0/0", bus.out_valid, bus.im_ce); end
    n_vec++; if (bus.out_pc !== '0 || bus.out_instr !== '0) begin n_err++; $display("FAIL mid_rst_data: got pc %h instr %h want 0/0", bus.out_pc, bus.out_instr); end
    repeat (2) @(negedge clk);
    release_reset(1'b1);
    n_vec++; if (bus.im_ce !== 1'b1 || bus.im_address !== 10'd0) begin n_err++; $display("FAIL mid_restart: got ce %b addr %h want 1/0", bus.im_ce, bus.im_address); end
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 10'd0 || bus.out_instr !== 32'd100) begin n_err++; $display("FAIL mid_first_out: got valid %b pc %h instr %h want 1/0/100", bus.out_valid, bus.out_pc, bus.out_instr); end
  endtask

  typedef struct {
    logic [AW-1:0] pc;
    int            t;
  } ent_t;

  task automatic test_random();
    ent_t          q[$];
    ent_t          e;
    logic [AW-1:0] fetch_pc;
    logic          rv, rdy, exp_ce, exp_valid;
    logic [AW-1:0] rpc;
    int            accepted;
    do_reset();
    spur_en  = 1'b1;
    fetch_pc = '0;
    accepted = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 0) begin
        rv = 1'b0; rpc = '0; rdy = 1'b0;
        release_reset(rdy);
      end else begin
        rv  = ($urandom % 100) < 3;
        rpc = AW'($urandom);
        rdy = ($urandom % 10) < 7;
        step(rv, rpc, rdy);
      end
      exp_ce    = !rv && (q.size() < DEPTH);
      exp_valid = !rv && (q.size() > 0) && (q[0].t <= cyc);
      n_vec++; if (bus.im_ce !== exp_ce) begin n_err++; $display("FAIL rnd_ce@%0d: got %b want %b", cyc, bus.im_ce, exp_ce); end
      if (exp_ce) begin
        n_vec++; if (bus.im_address !== fetch_pc) begin n_err++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, bus.im_address, fetch_pc); end
      end
      n_vec++; if (bus.out_valid !== exp_valid) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, bus.out_valid, exp_valid); end
      if (exp_valid) begin
        n_vec++; if (bus.out_pc !== q[0].pc || bus.out_instr !== word(q[0].pc)) begin n_err++; $display("FAIL rnd_head@%0d: got pc %h instr %h want %h/%h", cyc, bus.out_pc, bus.out_instr, q[0].pc, word(q[0].pc)); end
      end
      if (rv) begin
        q.delete();
        fetch_pc = rpc;
      end else begin
        if (exp_valid && rdy) begin
          void'(q.pop_front());
          accepted++;
        end
        if (exp_ce) begin
          e.pc = fetch_pc;
          e.t  = cyc + 2;
          q.push_back(e);
          fetch_pc = fetch_pc + 1'b1;
        end
      end
    end
    spur_en = 1'b0;
    n_vec++; if (accepted < 1000) begin n_err++; $display("FAIL rnd_throughput: got %0d accepted want >= 1000", accepted); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
